operand_loader: RTL and testbench

Sequential front end for the 4-bit adder datapath. Captures operand X, then operand Y and carry-in, from slide switches on successive presses of a load key. Presents them as stable registered outputs that drive the adder's X, Y and Cin inputs directly. Asserts Valid once a complete operand pair is held, so downstream display logic shows the sum only when both operands are loaded.

---
 rtl/operand_loader_if.sv | 24 ++
 rtl/operand_loader.sv | 120 ++++++++++++
 tb/tb_operand_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/operand_loader_if.sv
// Operand loader bus: switch/key inputs toward the loader and the captured operand outputs.
interface operand_loader_if #(
    parameter int W = 4
);
    logic [W-1:0] data;
    logic         cin_sw;
    logic         load;
    logic         clear;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic         valid;
    logic [1:0]   state;

    modport master (
        output data, cin_sw, load, clear,
        input  x, y, cin, valid, state
    );

    modport slave (
        input  data, cin_sw, load, clear,
        output x, y, cin, valid, state
    );
endinterface

// File: rtl/operand_loader.sv
// Captures X, then Y and carry-in, on successive load-key presses for the adder datapath.
// Optional load-key debounce filter enabled by defining OPLOAD_DEBOUNCE_EN.
module operand_loader #(
    parameter int W         = 4,
    parameter int DB_CYCLES = 4
) (
    input  logic            clock,
    input  logic            resetn,
    operand_loader_if.slave bus
);
    typedef enum logic [1:0] {
        GET_X = 2'b00,
        GET_Y = 2'b01,
        READY = 2'b10
    } state_t;

    if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_db_range
        $error("DB_CYCLES must be in 1..255");
    end

    logic         l1_reg, l2_reg, c1_reg, c2_reg;
    logic         ld;
    logic         ld_q_reg;
    logic         load_rise;
    logic [W-1:0] x_reg, y_reg;
    logic         cin_reg, valid_reg;
    state_t       state_reg;

`ifdef OPLOAD_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          ld_reg;
    logic [CW-1:0] cnt_reg;

    // ld only follows l2 once l2 has disagreed with it for DB_CYCLES cycles in a row
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ld_reg  <= 1'b0;
            cnt_reg <= '0;
        end else if (l2_reg == ld_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CW'(DB_CYCLES - 1)) begin
            ld_reg  <= l2_reg;
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign ld = ld_reg;
`else
    assign ld = l2_reg;
`endif

    assign load_rise = ld & ~ld_q_reg;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            l1_reg    <= 1'b0;
            l2_reg    <= 1'b0;
            c1_reg    <= 1'b0;
            c2_reg    <= 1'b0;
            ld_q_reg  <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
            cin_reg   <= 1'b0;
            valid_reg <= 1'b0;
            state_reg <= GET_X;
        end else begin
            l1_reg   <= bus.load;
            l2_reg   <= l1_reg;
            c1_reg   <= bus.clear;
            c2_reg   <= c1_reg;
            // ld_q keeps tracking during clear so a key held through clear cannot fire afterwards
            ld_q_reg <= ld;

            if (c2_reg) begin
                x_reg     <= '0;
                y_reg     <= '0;
                cin_reg   <= 1'b0;
                valid_reg <= 1'b0;
                state_reg <= GET_X;
            end else begin
                case (state_reg)
                    GET_X: begin
                        if (load_rise) begin
                            x_reg     <= bus.data;
                            state_reg <= GET_Y;
                        end
                    end
                    GET_Y: begin
                        if (load_rise) begin
                            y_reg     <= bus.data;
                            cin_reg   <= bus.cin_sw;
                            valid_reg <= 1'b1;
                            state_reg <= READY;
                        end
                    end
                    READY: begin
                        if (load_rise) begin
                            x_reg     <= bus.data;
                            valid_reg <= 1'b0;
                            state_reg <= GET_Y;
                        end
                    end
                    default: begin
                        valid_reg <= 1'b0;
                        state_reg <= GET_X;
                    end
                endcase
            end
        end
    end

    assign bus.x     = x_reg;
    assign bus.y     = y_reg;
    assign bus.cin   = cin_reg;
    assign bus.valid = valid_reg;
    assign bus.state = state_reg;
endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: stimulus queues expected output changes, a monitor checks them.
module tb_operand_loader;
`ifdef OPLOAD_DEBOUNCE_EN
    localparam int LAT = 3 + 4;
`else
    localparam int LAT = 3;
`endif
    localparam int GAP = 16;

    logic clock = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic done = 1'b0;

    operand_loader_if #(.W(4)) bus ();

    operand_loader #(.W(4), .DB_CYCLES(4)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       cin;
        logic       valid;
        logic [1:0] state;
        int         at;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push(input logic [3:0] x, input logic [3:0] y, input logic cin,
                        input logic valid, input logic [1:0] state, input int at);
        exp_t e;
        e.x = x; e.y = y; e.cin = cin; e.valid = valid; e.state = state; e.at = at;
        sb.push_back(e);
    endtask

    // Press Load for len cycles with the given switches; expected outputs are hand-computed by caller
    task automatic press(input logic [3:0] d, input logic c, input int len,
                         input logic [3:0] ex, input logic [3:0] ey, input logic ec,
                         input logic ev, input logic [1:0] es);
        @(negedge clock);
        bus.data = d; bus.cin_sw = c; bus.load = 1'b1;
        push(ex, ey, ec, ev, es, cyc + LAT);
        repeat (len) @(negedge clock);
        bus.load = 1'b0;
        repeat (GAP) @(negedge clock);
    endtask

    // Monitor: every output change must match the head of the scoreboard at the expected cycle
    logic [11:0] prev = '0;
    always @(negedge clock) begin
        logic [11:0] cur;
        exp_t e;
        cur = {bus.x, bus.y, bus.cin, bus.valid, bus.state};
        if (!done) begin
            if (!resetn) begin
                check("reset_outputs", int'(cur), 0);
            end else if (cur != prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_change", int'(cur), int'(prev));
                end else begin
                    e = sb.pop_front();
                    check("outputs", int'(cur), int'({e.x, e.y, e.cin, e.valid, e.state}));
                    check("latency_cycle", cyc, e.at);
                end
            end
        end
        prev = cur;
    end

    initial begin
        resetn = 1'b0;
        bus.load = 1'b1; bus.data = 4'hF; bus.cin_sw = 1'b0; bus.clear = 1'b0;
        repeat (5) @(negedge clock);
        bus.load = 1'b0;
        resetn = 1'b1;
        repeat (3) @(negedge clock);

        // Basic pair
        press(4'h5, 1'b0, 10, 4'h5, 4'h0, 1'b0, 1'b0, 2'b01);
        press(4'hA, 1'b1, 10, 4'h5, 4'hA, 1'b1, 1'b1, 2'b10);
        check("adder_sum", int'(bus.x) + int'(bus.y) + int'(bus.cin), 16);

        // Reload from READY
        press(4'h7, 1'b0, 10, 4'h7, 4'hA, 1'b1, 1'b0, 2'b01);

        // Clear and Load together in GET_Y: clear wins, no capture
        @(negedge clock);
        bus.clear = 1'b1; bus.load = 1'b1; bus.data = 4'hE;
        push(4'h0, 4'h0, 1'b0, 1'b0, 2'b00, cyc + 3);
        repeat (12) @(negedge clock);
        bus.clear = 1'b0; bus.load = 1'b0;
        repeat (GAP) @(negedge clock);

        // Async reset in the middle of GET_Y
        press(4'h2, 1'b0, 10, 4'h2, 4'h0, 1'b0, 1'b0, 2'b01);
        @(negedge clock);
        #2 resetn = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 resetn = 1'b1;
        repeat (4) @(negedge clock);

        // Held key with switch change mid-hold: one capture only
        @(negedge clock);
        bus.data = 4'h3; bus.load = 1'b1;
        push(4'h3, 4'h0, 1'b0, 1'b0, 2'b01, cyc + LAT);
        repeat (10) @(negedge clock);
        bus.data = 4'hC;
        repeat (10) @(negedge clock);
        bus.load = 1'b0;
        repeat (GAP) @(negedge clock);

`ifdef OPLOAD_DEBOUNCE_EN
        // 3-cycle glitch must not capture
        @(negedge clock);
        bus.data = 4'h9; bus.load = 1'b1;
        repeat (3) @(negedge clock);
        bus.load = 1'b0;
        repeat (GAP) @(negedge clock);
`endif

        press(4'h6, 1'b1, 10, 4'h3, 4'h6, 1'b1, 1'b1, 2'b10);

        check("scoreboard_drained", sb.size(), 0);
        check("final_x", int'(bus.x), 3);
        check("final_state", int'(bus.state), 2);
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
